mmio_bus_ctrl: RTL

- Parametrised memory-mapped bus controller between the MIPS core data port and N slaves (data memory, factorial accelerator, GPIO, future peripherals).
- Decodes each access against per-slave base/mask regions and drives one-hot slave select and write enable.
- Waits for a slave ready handshake, registers the returned read data, and reports done or error to the core.
- Unmapped accesses and slaves that never respond end with an error response, so the core never hangs.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/mmio_region_match.sv | 28 ++
 rtl/mmio_bus_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state encoding, default decode map and region match helper
// for the MMIO bus controller.
package mmio_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEC_LSB_DEF = 4;
    localparam int DEC_MSB_DEF = 8;

    localparam logic [4:0] DMEM_BASE = 5'h00;
    localparam logic [4:0] DMEM_MASK = 5'h10;
    localparam logic [4:0] FACT_BASE = 5'h10;
    localparam logic [4:0] FACT_MASK = 5'h1F;
    localparam logic [4:0] GPIO_BASE = 5'h12;
    localparam logic [4:0] GPIO_MASK = 5'h1F;

    function automatic logic region_hit(input logic [31:0] field, input logic [31:0] base,
                                        input logic [31:0] mask);
        return (field & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/mmio_region_match.sv
// mmio_region_match: combinational address-field decoder; the lowest-index
// matching region wins when regions overlap.
module mmio_region_match
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int FW = 5,
    parameter int IDX_W = 2,
    parameter logic [NUM_SLAVES*FW-1:0] SLV_BASE = {GPIO_BASE, FACT_BASE, DMEM_BASE},
    parameter logic [NUM_SLAVES*FW-1:0] SLV_MASK = {GPIO_MASK, FACT_MASK, DMEM_MASK}
) (
    input  logic [FW-1:0]    field,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region_hit(32'(field), 32'(SLV_BASE[i*FW +: FW]), 32'(SLV_MASK[i*FW +: FW]))) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: routes one core data access at a time to a decoded slave,
// waits for its ready (bounded by TIMEOUT) and returns done/err plus read data.
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEC_LSB = DEC_LSB_DEF,
    parameter int DEC_MSB = DEC_MSB_DEF,
    parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] SLV_BASE = {GPIO_BASE, FACT_BASE, DMEM_BASE},
    parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] SLV_MASK = {GPIO_MASK, FACT_MASK, DMEM_MASK},
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_done,
    output logic                         m_err,
    output logic                         m_busy,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [NUM_SLAVES-1:0]        s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_rdy
);

    localparam int FW = DEC_MSB - DEC_LSB + 1;
    localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx, w_idx;
    logic                r_we, r_err, w_hit, w_rdy, w_tmo;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata, w_slice;
    logic [NUM_SLAVES-1:0] w_sel;

    mmio_region_match #(
        .NUM_SLAVES(NUM_SLAVES),
        .FW        (FW),
        .IDX_W     (IDX_W),
        .SLV_BASE  (SLV_BASE),
        .SLV_MASK  (SLV_MASK)
    ) u_match (
        .field(m_addr[DEC_MSB:DEC_LSB]),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    // Only the selected slave's ready and data are visible to the FSM.
    always_comb begin
        w_rdy   = 1'b0;
        w_slice = '0;
        w_sel   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_rdy    = s_rdy[i];
                w_slice  = s_rdata[i*DATA_W +: DATA_W];
                w_sel[i] = r_state == WAIT;
            end
        end
    end

    assign w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = m_req ? (w_hit ? WAIT : RESP) : IDLE;
            WAIT:    w_state_nxt = (w_rdy || w_tmo) ? RESP : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (m_req) begin
                    r_addr  <= m_addr;
                    r_wdata <= m_wdata;
                    r_we    <= m_we;
                    r_idx   <= w_idx;
                    r_err   <= !w_hit;
                    r_cnt   <= '0;
                    if (!w_hit && !m_we) r_rdata <= '0;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_rdy) begin
                        r_err <= 1'b0;
                        if (!r_we) r_rdata <= w_slice;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                        if (!r_we) r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_sel   = w_sel;
    assign s_we    = w_sel & {NUM_SLAVES{r_we}};
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign m_rdata = r_rdata;
    assign m_done  = r_state == RESP;
    assign m_err   = (r_state == RESP) && r_err;
    assign m_busy  = r_state != IDLE;

endmodule
